// File: rtl/data_sram_responder_if.sv
// Core-side data SRAM bus: one request per cycle, read data returned on the following edge.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-writable word RAM plus an MMIO window (LED, switch, timer).
// Define RESP_PERF_CNT_EN to add RAM load/store counters at offsets F010/F014.
module data_sram_responder #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic                  clk,
  input  logic                  rst,
  data_sram_responder_if.slave  bus,
  output logic [15:0]           led,
  input  logic [7:0]            switch,
  output logic [31:0]           timer
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF004;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_LOADS  = 16'hF010;
  localparam logic [15:0] OFF_STORES = 16'hF014;

  // Replace the byte lanes selected by wen; unselected lanes keep their old value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdata_r;
  logic [15:0]       led_r;
  logic [31:0]       timer_r;
  logic [7:0]        sync1_r;
  logic [7:0]        sync2_r;

  logic              mmio_sel_s;
  logic [15:0]       off_s;
  logic [ADDR_W-1:0] idx_s;
  logic              rd_s;
  logic              wr_s;
  logic              ram_rd_s;
  logic              ram_wr_s;
  logic              led_wr_s;
  logic              timer_wr_s;
  logic [31:0]       led_merged_s;
  logic [31:0]       timer_merged_s;
  logic [31:0]       mmio_rdata_s;

`ifdef RESP_PERF_CNT_EN
  logic [31:0]       load_cnt_r;
  logic [31:0]       store_cnt_r;
  logic              load_clr_s;
  logic              store_clr_s;
`endif

  assign mmio_sel_s     = (bus.data_sram_addr[31:16] == MMIO_HI);
  assign off_s          = bus.data_sram_addr[15:0];
  assign idx_s          = bus.data_sram_addr[ADDR_W+1:2];
  assign rd_s           = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
  assign wr_s           = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
  assign ram_rd_s       = rd_s && !mmio_sel_s;
  assign ram_wr_s       = wr_s && !mmio_sel_s;
  assign led_wr_s       = wr_s && mmio_sel_s && (off_s == OFF_LED);
  assign timer_wr_s     = wr_s && mmio_sel_s && (off_s == OFF_TIMER);
  assign led_merged_s   = lane_merge({16'h0000, led_r}, bus.data_sram_wdata, bus.data_sram_wen);
  assign timer_merged_s = lane_merge(timer_r, bus.data_sram_wdata, bus.data_sram_wen);

`ifdef RESP_PERF_CNT_EN
  assign load_clr_s     = wr_s && mmio_sel_s && (off_s == OFF_LOADS);
  assign store_clr_s    = wr_s && mmio_sel_s && (off_s == OFF_STORES);
`endif

  assign bus.data_sram_rdata = rdata_r;
  assign led                 = led_r;
  assign timer               = timer_r;

  // MMIO read mux; registers sample their pre-edge value, unmapped offsets read zero.
  always_comb begin
    mmio_rdata_s = 32'h0000_0000;
    case (off_s)
      OFF_LED:    mmio_rdata_s = {16'h0000, led_r};
      OFF_SWITCH: mmio_rdata_s = {24'h00_0000, sync2_r};
      OFF_TIMER:  mmio_rdata_s = timer_r;
`ifdef RESP_PERF_CNT_EN
      OFF_LOADS:  mmio_rdata_s = load_cnt_r;
      OFF_STORES: mmio_rdata_s = store_cnt_r;
`endif
      default:    mmio_rdata_s = 32'h0000_0000;
    endcase
  end

  // RAM array write port; contents are not reset, but a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && ram_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i]) begin
          mem[idx_s][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data register: read-first on writes, holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 32'h0000_0000;
    end else if (bus.data_sram_en) begin
      rdata_r <= mmio_sel_s ? mmio_rdata_s : mem[idx_s];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // MMIO registers, free-running timer and two-flop switch synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r   <= 16'h0000;
      timer_r <= 32'h0000_0000;
      sync1_r <= 8'h00;
      sync2_r <= 8'h00;
    end else begin
      sync1_r <= switch;
      sync2_r <= sync1_r;
      if (led_wr_s) begin
        led_r <= led_merged_s[15:0];
      end else begin
        led_r <= led_r;
      end
      // A software write replaces that cycle's increment.
      if (timer_wr_s) begin
        timer_r <= timer_merged_s;
      end else begin
        timer_r <= timer_r + 32'd1;
      end
    end
  end

`ifdef RESP_PERF_CNT_EN
  // RAM access counters; a write to a counter's offset clears it ahead of any increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_r  <= 32'h0000_0000;
      store_cnt_r <= 32'h0000_0000;
    end else begin
      if (load_clr_s) begin
        load_cnt_r <= 32'h0000_0000;
      end else if (ram_rd_s) begin
        load_cnt_r <= load_cnt_r + 32'd1;
      end else begin
        load_cnt_r <= load_cnt_r;
      end
      if (store_clr_s) begin
        store_cnt_r <= 32'h0000_0000;
      end else if (ram_wr_s) begin
        store_cnt_r <= store_cnt_r + 32'd1;
      end else begin
        store_cnt_r <= store_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: expected read data is queued when a read is issued
// and checked one edge later.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] led;
  logic [7:0]  switch;
  logic [31:0] timer;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

`ifdef RESP_PERF_CNT_EN
  localparam logic [31:0] EXP_LOADS  = 32'd3;
  localparam logic [31:0] EXP_STORES = 32'd2;
`else
  localparam logic [31:0] EXP_LOADS  = 32'd0;
  localparam logic [31:0] EXP_STORES = 32'd0;
`endif

  data_sram_responder_if bus ();

  data_sram_responder dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .led    (led),
    .switch (switch),
    .timer  (timer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of bus inputs and sample 1 ns after the edge.
  task automatic step(input logic r, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
    rst                 = r;
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check();
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 32'h0000_0001, 32'h0000_0000);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, bus.data_sram_rdata, e);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step(1'b0, 1'b1, 4'b0000, addr, 32'h0000_0000);
    pop_check();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    step(1'b0, 1'b1, wen, addr, wdata);
  endtask

  task automatic wr_pre(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                        input logic [31:0] pre, input string tag);
    exp_q.push_back(pre);
    tag_q.push_back(tag);
    step(1'b0, 1'b1, wen, addr, wdata);
    pop_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000);
    end
  endtask

  initial begin
    switch = 8'h00;

    // Reset values
    step(1'b1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000);
    step(1'b1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000);
    check("rst_rdata", bus.data_sram_rdata, 32'h0000_0000);
    check("rst_led", {16'h0000, led}, 32'h0000_0000);
    check("rst_timer", timer, 32'h0000_0000);

    // Timer: ten idle edges after reset, read returns pre-edge value
    idle(10);
    rd(32'hBFAF_E000, 32'd10, "timer_after_10");

    // RAM byte lanes, read-first and write-then-read
    wr(32'h0000_0100, 4'hF, 32'h1122_3344);
    wr_pre(32'h0000_0100, 4'b0010, 32'h0000_AA00, 32'h1122_3344, "read_first");
    rd(32'h0000_0100, 32'h1122_AA44, "byte_lane");

    // Back-to-back writes then reads
    wr(32'h0000_0000, 4'hF, 32'hA0A0_0000);
    wr(32'h0000_0004, 4'hF, 32'hA4A4_0004);
    wr(32'h0000_0008, 4'hF, 32'hA8A8_0008);
    rd(32'h0000_0008, 32'hA8A8_0008, "b2b_rd8");
    rd(32'h0000_0004, 32'hA4A4_0004, "b2b_rd4");
    rd(32'h0000_0000, 32'hA0A0_0000, "b2b_rd0");
    rd(32'h0000_0008, 32'hA8A8_0008, "b2b_rd8_again");
    idle(1);
    check("idle_hold", bus.data_sram_rdata, 32'hA8A8_0008);

    // Upper address bits outside the window alias onto the RAM
    wr(32'h0000_0010, 4'hF, 32'h5555_AAAA);
    rd(32'h1234_0010, 32'h5555_AAAA, "alias_hi");
    rd(32'h0000_4010, 32'h5555_AAAA, "alias_bit14");

    // LED register, full and lane-masked writes
    wr(32'hBFAF_F000, 4'hF, 32'h0000_BEEF);
    check("led_write", {16'h0000, led}, 32'h0000_BEEF);
    wr(32'hBFAF_F000, 4'b0001, 32'hFFFF_FF12);
    check("led_lane", {16'h0000, led}, 32'h0000_BE12);
    rd(32'hBFAF_F000, 32'h0000_BE12, "led_read");

    // Switch through the synchronizer; writes to it are ignored
    switch = 8'h5A;
    idle(2);
    rd(32'hBFAF_F004, 32'h0000_005A, "switch_read");
    wr(32'hBFAF_F004, 4'hF, 32'hFFFF_FFFF);
    rd(32'hBFAF_F004, 32'h0000_005A, "switch_ro");

    // Unmapped MMIO offset
    rd(32'hBFAF_1234, 32'h0000_0000, "unmapped");

    // Timer write and wrap
    wr(32'hBFAF_E000, 4'hF, 32'hFFFF_FFFE);
    check("timer_write", timer, 32'hFFFF_FFFE);
    idle(1);
    rd(32'hBFAF_E000, 32'hFFFF_FFFF, "timer_max");
    rd(32'hBFAF_E000, 32'h0000_0000, "timer_wrap");

    // Reset in the same cycle as accesses: accesses dropped, outputs cleared
    wr(32'h0000_0200, 4'hF, 32'hCAFE_F00D);
    rd(32'h0000_0200, 32'hCAFE_F00D, "pre_reset_rd");
    step(1'b1, 1'b1, 4'hF, 32'hBFAF_F000, 32'h0000_FFFF);
    check("midrst_led", {16'h0000, led}, 32'h0000_0000);
    check("midrst_rdata", bus.data_sram_rdata, 32'h0000_0000);
    check("midrst_timer", timer, 32'h0000_0000);
    step(1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
    check("midrst_timer2", timer, 32'h0000_0000);
    rd(32'h0000_0200, 32'hCAFE_F00D, "ram_survives_rst");

    // Perf counters: three RAM reads (including the one above) and two RAM writes
    rd(32'h0000_0100, 32'h1122_AA44, "perf_rd2");
    rd(32'h0000_0000, 32'hA0A0_0000, "perf_rd3");
    wr(32'h0000_0300, 4'hF, 32'h0000_0300);
    wr(32'h0000_0304, 4'hF, 32'h0000_0304);
    rd(32'hBFAF_F010, EXP_LOADS, "load_cnt");
    rd(32'hBFAF_F014, EXP_STORES, "store_cnt");
    wr(32'hBFAF_F010, 4'hF, 32'h1234_5678);
    rd(32'hBFAF_F010, 32'h0000_0000, "load_cnt_clr");
    rd(32'hBFAF_F014, EXP_STORES, "store_cnt_kept");

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
